// File: rtl/mem_model_pkg.sv
// Shared definitions for the multi-channel slow memory model: FSM state
// encoding and width helpers.
package mem_model_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  // Width of an index/counter able to hold 0..v-1, never narrower than 1 bit.
  function automatic int unsigned idx_w(input int unsigned v);
    return (v > 1) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/multi_port_slow_memory_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester found scanning
// upward from ptr_i, wrapping modulo N_CH. Returns one-hot grant and its index.
module rr_arbiter
  import mem_model_pkg::*;
#(
  parameter int N_CH = 2
) (
  input  logic [N_CH-1:0]          req_i,
  input  logic [idx_w(N_CH)-1:0]   ptr_i,
  output logic [N_CH-1:0]          gnt_o,
  output logic [idx_w(N_CH)-1:0]   gnt_idx_o
);

  localparam int CH_W = idx_w(N_CH);

  // Scan from the pointer, first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      int unsigned j;
      logic [CH_W-1:0] jj;
      j = 32'(ptr_i) + i;
      if (j >= N_CH) j = j - N_CH;
      jj = CH_W'(j);
      if (req_i[jj] && (gnt_o == '0)) begin
        gnt_o[jj] = 1'b1;
        gnt_idx_o = jj;
      end
    end
  end

endmodule

// File: rtl/multi_port_slow_memory.sv
// Multi-channel slow line memory: N_CH masters share one line store through a
// round-robin arbiter; each transaction completes LAT cycles after its grant.
// Optional per-channel statistics counters are built when MEM_STATS_EN is
// defined (rd_cnt, wr_cnt, wait_cyc; read hierarchically, no ports).
module multi_port_slow_memory
  import mem_model_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 28,
  parameter int DEPTH  = 1024,
  parameter int LAT    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          read,
  input  logic [N_CH-1:0]          write,
  input  logic [N_CH*ADDR_W-1:0]   addr,
  input  logic [N_CH*LINE_W-1:0]   wdata,
  output logic [N_CH*LINE_W-1:0]   rdata,
  output logic [N_CH-1:0]          ready
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam int CH_W  = idx_w(N_CH);
  localparam int CNT_W = idx_w(LAT);

  // Line store; deliberately not reset so benches can preload it.
  logic [LINE_W-1:0] mem [DEPTH];

  state_e               state_q;
  logic [CH_W-1:0]      ch_q;
  logic                 op_wr_q;
  logic [IDX_W-1:0]     idx_q;
  logic [LINE_W-1:0]    wdata_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CH_W-1:0]      rr_ptr_q;
  logic [N_CH-1:0]      ready_q;
  logic [N_CH*LINE_W-1:0] rdata_q;

  logic [N_CH-1:0]      req;
  logic [N_CH-1:0]      gnt;
  logic [CH_W-1:0]      gnt_idx;
  logic                 done_now;

  // Upper address bits are ignored by design (addresses alias modulo DEPTH).
  logic unused_addr;
  assign unused_addr = ^addr;

  assign req      = read | write;
  assign done_now = (state_q == WAIT) && (cnt_q == '0);
  assign rdata    = rdata_q;
  assign ready    = ready_q;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Transaction FSM: grant/latch in IDLE, count in WAIT, complete on the edge
  // into DONE so ready/rdata are valid during the DONE cycle. DONE always
  // returns to IDLE, so a request still held through ready is not re-granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      op_wr_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      ready_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= '0;
          if (|gnt) begin
            ch_q    <= gnt_idx;
            op_wr_q <= write[gnt_idx];
            idx_q   <= addr[gnt_idx*ADDR_W +: IDX_W];
            wdata_q <= wdata[gnt_idx*LINE_W +: LINE_W];
            cnt_q   <= CNT_W'(LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            ready_q[ch_q] <= 1'b1;
            if (!op_wr_q) rdata_q[ch_q*LINE_W +: LINE_W] <= mem[idx_q];
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          ready_q  <= '0;
          rr_ptr_q <= (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line write lands on the same edge that raises ready.
  always_ff @(posedge clk) begin
    if (done_now && op_wr_q) mem[idx_q] <= wdata_q;
  end

`ifdef MEM_STATS_EN
  logic [31:0] rd_cnt   [N_CH];
  logic [31:0] wr_cnt   [N_CH];
  logic [31:0] wait_cyc [N_CH];

  logic [N_CH-1:0] own_v, rd_done_v, wr_done_v, stall_v;

  // Per-channel event vectors: completions, and cycles spent requesting
  // without being granted or already in flight.
  always_comb begin
    own_v     = (state_q != IDLE) ? (N_CH'(1) << ch_q) : '0;
    rd_done_v = (done_now && !op_wr_q) ? own_v : '0;
    wr_done_v = (done_now &&  op_wr_q) ? own_v : '0;
    stall_v   = req & ~((state_q == IDLE) ? gnt : '0) & ~own_v;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        rd_cnt[c]   <= '0;
        wr_cnt[c]   <= '0;
        wait_cyc[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (rd_done_v[c] && (rd_cnt[c] != '1))   rd_cnt[c]   <= rd_cnt[c] + 32'd1;
        if (wr_done_v[c] && (wr_cnt[c] != '1))   wr_cnt[c]   <= wr_cnt[c] + 32'd1;
        if (stall_v[c]   && (wait_cyc[c] != '1)) wait_cyc[c] <= wait_cyc[c] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_port_slow_memory.sv
// Directed bench for multi_port_slow_memory (N_CH=2, LAT=8, DEPTH=1024).
// Drivers push expected completions into a scoreboard; a monitor pops and
// checks each ready pulse for cycle, channel and read data.
module tb_multi_port_slow_memory;

  localparam int N_CH   = 2;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_CH-1:0]        read = '0;
  logic [N_CH-1:0]        write = '0;
  logic [N_CH*ADDR_W-1:0] addr = '0;
  logic [N_CH*LINE_W-1:0] wdata = '0;
  logic [N_CH*LINE_W-1:0] rdata;
  logic [N_CH-1:0]        ready;

  multi_port_slow_memory #(
    .N_CH(N_CH), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .read(read), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int rd0   = 0;

  typedef struct {
    int          ch;
    bit          wr;
    logic [127:0] data;
    int          cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] model [int];

  localparam logic [127:0] L_A5 = {16{8'hA5}};
  localparam logic [127:0] L_C3 = {16{8'hC3}};
  localparam logic [127:0] L_5A = {16{8'h5A}};
  localparam logic [127:0] L_FF = {16{8'hFF}};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_ch(input int ch, input bit rd, input bit wr,
                        input logic [27:0] a, input logic [127:0] d);
    read[ch]  = rd;
    write[ch] = wr;
    addr[ch*ADDR_W +: ADDR_W]  = a;
    wdata[ch*LINE_W +: LINE_W] = d;
  endtask

  task automatic push(input int ch, input bit wr, input logic [27:0] a,
                      input logic [127:0] d, input int at);
    exp_t e;
    int   idx;
    idx   = int'(a) & (DEPTH - 1);
    e.ch  = ch;
    e.wr  = wr;
    e.cyc = at;
    if (wr) begin
      model[idx] = d;
      e.data     = d;
    end else begin
      e.data = model.exists(idx) ? model[idx] : '0;
      if (ch == 0) rd0++;
    end
    sb.push_back(e);
  endtask

  task automatic wait_rdy(input int ch);
    int n;
    n = 0;
    while (ready[ch] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready[ch], 1'b1);
  endtask

  // Single master: hold request until ready, drop it the cycle after.
  task automatic do_req(input int ch, input bit rd, input bit wr,
                        input logic [27:0] a, input logic [127:0] d);
    set_ch(ch, rd, wr, a, d);
    push(ch, wr, a, d, cyc + 1 + LAT);
    wait_rdy(ch);
    @(negedge clk);
    set_ch(ch, 1'b0, 1'b0, a, d);
  endtask

  // Both channels request in the same cycle; 'first' is the expected winner.
  task automatic two_req(input int first,
                         input bit wr0, input logic [27:0] a0, input logic [127:0] d0,
                         input bit wr1, input logic [27:0] a1, input logic [127:0] d1);
    int g;
    int second;
    second = 1 - first;
    set_ch(0, !wr0, wr0, a0, d0);
    set_ch(1, !wr1, wr1, a1, d1);
    g = cyc + 1;
    if (first == 0) begin
      push(0, wr0, a0, d0, g + LAT);
      push(1, wr1, a1, d1, g + 2 * LAT + 2);
    end else begin
      push(1, wr1, a1, d1, g + LAT);
      push(0, wr0, a0, d0, g + 2 * LAT + 2);
    end
    wait_rdy(first);
    @(negedge clk);
    set_ch(first, 1'b0, 1'b0, '0, '0);
    wait_rdy(second);
    @(negedge clk);
    set_ch(second, 1'b0, 1'b0, '0, '0);
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ready !== '0) begin
      if (sb.size() == 0) begin
        check("spurious_ready", ready, '0);
      end else begin
        mon_e = sb.pop_front();
        check("ready_cycle", cyc, mon_e.cyc);
        check("ready_vec", ready, 2'b01 << mon_e.ch);
        if (!mon_e.wr) check("rdata", rdata[mon_e.ch*LINE_W +: LINE_W], mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", ready, '0);
    check("rst_rdata0", rdata[127:0], '0);
    check("rst_rdata1", rdata[255:128], '0);
    check("rst_rr_ptr", dut.rr_ptr_q, '0);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests from reset: ch0 first, then ch1.
    two_req(0, 1'b1, 28'h10, L_A5, 1'b1, 28'h30, L_C3);
    check("rr_ptr_after_pair", dut.rr_ptr_q, '0);

    // Write then read on ch0.
    do_req(0, 1'b0, 1'b1, 28'h10, L_A5);
    do_req(0, 1'b1, 1'b0, 28'h10, '0);
    check("rdata1_untouched", rdata[255:128], '0);

    // Address alias 0x410 -> line 0x010; other-channel rdata holds.
    do_req(1, 1'b1, 1'b0, 28'h410, '0);
    do_req(0, 1'b1, 1'b0, 28'h30, '0);
    check("rdata1_hold", rdata[255:128], L_A5);

    // read and write both set is a write; it does not disturb rdata.
    do_req(1, 1'b1, 1'b1, 28'h40, 128'h1);
    check("rdata1_after_wr", rdata[255:128], L_A5);
    do_req(0, 1'b1, 1'b0, 28'h40, '0);

    // Inputs changing after grant are ignored.
    set_ch(1, 1'b0, 1'b1, 28'h50, 128'h77);
    push(1, 1'b1, 28'h50, 128'h77, cyc + 1 + LAT);
    repeat (2) @(negedge clk);
    set_ch(1, 1'b0, 1'b1, 28'h51, 128'h88);
    wait_rdy(1);
    @(negedge clk);
    set_ch(1, 1'b0, 1'b0, '0, '0);
    do_req(1, 1'b1, 1'b0, 28'h50, '0);

    // After a ch0 completion rr_ptr=1, so ch1 wins a tie.
    do_req(0, 1'b1, 1'b0, 28'h10, '0);
    two_req(1, 1'b0, 28'h30, '0, 1'b0, 28'h40, '0);

    // Reset three cycles after grant of a write aborts it.
    do_req(0, 1'b0, 1'b1, 28'h20, L_5A);
    set_ch(0, 1'b0, 1'b1, 28'h20, L_FF);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", ready, '0);
    check("abort_rdata0", rdata[127:0], '0);
    check("abort_rdata1", rdata[255:128], '0);
    check("abort_rr_ptr", dut.rr_ptr_q, '0);
    @(negedge clk);
    set_ch(0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    rd0 = 0;
    repeat (LAT + 4) @(negedge clk);
    do_req(0, 1'b1, 1'b0, 28'h20, '0);

`ifdef MEM_STATS_EN
    check("rd_cnt0", dut.rd_cnt[0], 128'(rd0));
`endif

    check("sb_empty", 128'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
